// File: rtl/add3_share_sched_pkg.sv
// Package for the shared three-operand adder scheduler.
// Holds the default parameter values and the helper that sizes the
// requester-id field.
package add3_share_sched_pkg;

  localparam int NREQ_DEFAULT  = 4;
  localparam int W_DEFAULT     = 8;
  localparam int CNT_W_DEFAULT = 16;

  // Width of an encoded requester index. It is never below one bit, so
  // that an index field always exists.
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/add3_share_sched_rr_grant.sv
// rr_grant: combinational rotate-priority picker.
// The search starts at index ptr and wraps from NREQ-1 to 0. The first
// valid index found wins.
// Ports:
//   valid  in   NREQ   request vector
//   ptr    in   ID_W   round-robin start index
//   grant  out  NREQ   one-hot grant (all zero when nothing is valid)
//   idx    out  ID_W   encoded index of the grant
//   any    out  1      at least one request is valid
module rr_grant
  import add3_share_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int ID_W = id_width(NREQ_DEFAULT)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int cand;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/add3_share_sched.sv
// add3_share_sched: round-robin scheduler in front of one shared two-stage
// adder that computes x+y+z.
// Each cycle at most one requester is granted. Its operands enter stage 1
// (x+y, with z carried along). Stage 2 adds z and drives the response.
// The latency from accept to response is two edges.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active-high
//   req_valid  in   NREQ       per-requester valid
//   req_ready  out  NREQ       one-hot grant (combinational)
//   req_x/y/z  in   NREQ*W     operands; requester i at [i*W +: W]
//   rsp_valid  out  1          one-cycle result pulse
//   rsp_id     out  ID_W       owner of rsp_sum
//   rsp_sum    out  W          (x+y+z) mod 2^W
//   idle       out  1          no request valid and pipe empty
//   op_count   out  CNT_W      saturating count of accepted operations
module add3_share_sched
  import add3_share_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int ID_W  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_z,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              idle,
  output logic [CNT_W-1:0]  op_count
);

  logic [ID_W-1:0] ptr_r;
  logic [NREQ-1:0] grant_s;
  logic [ID_W-1:0] grant_idx_s;
  logic            grant_any_s;
  logic            accept_s;
  logic [W-1:0]    sel_x_s;
  logic [W-1:0]    sel_y_s;
  logic [W-1:0]    sel_z_s;

  logic            s1_v_r;
  logic [W-1:0]    s1_sum_r;
  logic [W-1:0]    s1_z_r;
  logic [ID_W-1:0] s1_id_r;

  rr_grant #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_grant (
    .valid (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (grant_idx_s),
    .any   (grant_any_s)
  );

  // Grants are suppressed during reset so that nothing is accepted on a
  // reset edge.
  always_comb begin
    if (rst) begin
      req_ready = '0;
      accept_s  = 1'b0;
    end else begin
      req_ready = grant_s;
      accept_s  = grant_any_s;
    end
  end

  // Select the operands of the granted requester.
  always_comb begin
    sel_x_s = req_x[grant_idx_s*W +: W];
    sel_y_s = req_y[grant_idx_s*W +: W];
    sel_z_s = req_z[grant_idx_s*W +: W];
  end

  // The round-robin pointer advances past the winner; it holds when
  // nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (accept_s) begin
      if (grant_idx_s == ID_W'(NREQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= grant_idx_s + ID_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Stage 1: form the partial sum x+y and carry z and the id forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r   <= 1'b0;
      s1_sum_r <= '0;
      s1_z_r   <= '0;
      s1_id_r  <= '0;
    end else if (accept_s) begin
      s1_v_r   <= 1'b1;
      s1_sum_r <= sel_x_s + sel_y_s;
      s1_z_r   <= sel_z_s;
      s1_id_r  <= grant_idx_s;
    end else begin
      s1_v_r   <= 1'b0;
      s1_sum_r <= s1_sum_r;
      s1_z_r   <= s1_z_r;
      s1_id_r  <= s1_id_r;
    end
  end

  // Stage 2: finish the add. Data holds across bubbles, so rsp_sum and
  // rsp_id keep their last values while rsp_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (s1_v_r) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= s1_sum_r + s1_z_r;
      rsp_id    <= s1_id_r;
    end else begin
      rsp_valid <= 1'b0;
      rsp_sum   <= rsp_sum;
      rsp_id    <= rsp_id;
    end
  end

  // The accepted-operation counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (accept_s && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + CNT_W'(1);
    end else begin
      op_count <= op_count;
    end
  end

  // Idle when no request is pending and neither pipe stage holds work.
  always_comb begin
    idle = ~(|req_valid) & ~s1_v_r & ~rsp_valid;
  end

endmodule

// File: tb/tb_add3_share_sched.sv
// Self-checking bench for add3_share_sched (NREQ=4, W=8, CNT_W=16).
// A behavioural model tracks the round-robin pointer, a two-deep queue of
// expected results and the operation count. Every cycle the bench checks
// the DUT outputs against this model. Directed scenarios come first, then
// randomized traffic with occasional resets.
module tb_add3_share_sched;

  localparam int NREQ  = 4;
  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ID_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ*W-1:0] req_z;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              idle;
  logic [CNT_W-1:0]  op_count;

  add3_share_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .idle      (idle),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_ptr;
  int m_cnt;
  bit m_s1_v, m_s2_v;
  int m_s1_id, m_s1_sum;
  int m_s2_id, m_s2_sum;
  int last_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_model(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0;
    m_s1_v = 0; m_s2_v = 0;
    m_s1_id = 0; m_s1_sum = 0;
    m_s2_id = 0; m_s2_sum = 0;
  endtask

  task automatic set_req(input int i, input bit v, input int x, input int y, input int z);
    req_valid[i]     = v;
    req_x[i*W +: W]  = W'(x);
    req_y[i*W +: W]  = W'(y);
    req_z[i*W +: W]  = W'(z);
  endtask

  // One clock cycle: check outputs at the negedge, advance the model at
  // the posedge, and return #1 after the edge so the caller can drive.
  task automatic cycle();
    int g;
    int sum;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    g  = rst ? -1 : pick_model(req_valid, m_ptr);
    eg = (g < 0) ? '0 : (NREQ'(1) << g);
    sum = 0;
    if (g >= 0) begin
      sum = (int'(req_x[g*W +: W]) + int'(req_y[g*W +: W]) + int'(req_z[g*W +: W])) % 256;
    end
    check("req_ready", 32'(req_ready), 32'(eg));
    check("rsp_valid", 32'(rsp_valid), 32'(m_s2_v));
    check("rsp_id", 32'(rsp_id), 32'(m_s2_id));
    check("rsp_sum", 32'(rsp_sum), 32'(m_s2_sum));
    check("idle", 32'(idle), 32'((req_valid == '0) && !m_s1_v && !m_s2_v));
    check("op_count", 32'(op_count), 32'(m_cnt));
    last_grant = g;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_s2_v = m_s1_v;
      if (m_s1_v) begin
        m_s2_id = m_s1_id; m_s2_sum = m_s1_sum;
      end
      m_s1_v = (g >= 0);
      if (g >= 0) begin
        m_s1_id = g; m_s1_sum = sum;
        m_ptr = (g + 1) % NREQ;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
    #1;
  endtask

  // Refresh a requester only once it has been granted or is idle.
  task automatic random_traffic(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant == i || !req_valid[i]) begin
          set_req(i, $urandom_range(0, 99) < 60, $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
        end else if ($urandom_range(0, 99) < 5) begin
          req_valid[i] = 1'b0;
        end
      end
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_z = '0;
    last_grant = -1;
    model_reset();
    @(posedge clk); #1;
    cycle();                       // reset state checked under rst=1
    rst = 1'b0;
    cycle();

    // Requester 2 alone: 3+4+5 = 12.
    set_req(2, 1, 3, 4, 5);
    #1 check("t1_ready", 32'(req_ready), 32'(4'b0100));
    cycle();
    req_valid = '0;
    cycle();
    check("t1_rsp_valid", 32'(rsp_valid), 32'(1));
    check("t1_sum", 32'(rsp_sum), 32'(12));
    check("t1_id", 32'(rsp_id), 32'(2));
    cycle();

    // Wrapping arithmetic: 200+100+10 = 54.
    set_req(0, 1, 200, 100, 10);
    cycle();
    req_valid = '0;
    cycle();
    check("t2_sum", 32'(rsp_sum), 32'(54));
    check("t2_id", 32'(rsp_id), 32'(0));
    check("t2_count", 32'(op_count), 32'(2));
    cycle();

    // Reset, then all four valid for six cycles: grants 0,1,2,3,0,1.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 10 * c + i, 1, 2);
      #1 check("t3_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
      cycle();
    end
    req_valid = '0;
    cycle(); cycle(); cycle();

    // Pointer at 2 after a grant to 1; valid=1010 -> grant 3 then 1.
    rst = 1'b1; cycle(); rst = 1'b0;
    set_req(1, 1, 1, 1, 1);
    cycle();
    set_req(1, 1, 7, 8, 9); set_req(3, 1, 50, 60, 70);
    #1 check("t4_first", 32'(req_ready), 32'(4'b1000));
    cycle();
    req_valid[3] = 1'b0;
    #1 check("t4_second", 32'(req_ready), 32'(4'b0010));
    cycle();
    req_valid = '0;
    check("t4_rsp_id3", 32'(rsp_id), 32'(3));
    cycle();
    check("t4_rsp_id1", 32'(rsp_id), 32'(1));

    // No requests for five cycles, then the pointer (still 2) decides.
    for (int c = 0; c < 5; c++) cycle();
    check("t6_idle", 32'(idle), 32'(1));
    for (int i = 0; i < NREQ; i++) set_req(i, 1, i, i, i);
    #1 check("t6_ptr_kept", 32'(req_ready), 32'(4'b0100));
    cycle();
    cycle();

    // Two operations in flight, then a one-cycle reset.
    rst = 1'b1; cycle(); rst = 1'b0;
    check("t5_rsp_valid", 32'(rsp_valid), 32'(0));
    check("t5_count", 32'(op_count), 32'(0));
    req_valid = '0;
    cycle(); cycle();

    random_traffic(600);
    rst = 1'b0; req_valid = '0;
    cycle(); cycle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
